usrt_rx: RTL and testbench
==========================

# usrt_rx

Synchronous serial (USRT) receiver: the far-end counterpart of the top-level USRT transmitter that drives `RTS`/`TXD` against `usrt_clk`. It runs entirely on the system clock `clk`. It treats `usrt_clk`, the serial data line and the peer's RTS as asynchronous inputs: each is synchronised, and the receiver samples the data line on every rising edge of `usrt_clk`. Each valid frame is deframed into a parallel byte and presented with a one-cycle strobe to the consuming logic.

## Interface
- `DATA_BITS`, 8, number of data bits per frame, LSB first.
- `clk` input 1: system clock; the only clock in the block.
- `rst` input 1: synchronous, active-high reset.
- `usrt_clk` input 1: serial bit clock from the transmitter, treated as data and synchronised.
- `rxd` input 1: serial data line; idle level is 1.
- `rts_in` input 1: peer RTS; high for the whole duration of a frame.
- `rx_data` output DATA_BITS: last correctly received word; holds its value until the next good frame.
- `rx_valid` output 1: one-`clk` strobe, `rx_data` updated.
- `frame_err` output 1: one-`clk` strobe on bad stop bit or RTS drop mid-frame.
- `par_err` output 1: one-`clk` strobe on parity mismatch; tied 0 without the macro.
- `busy` output 1: high while the FSM is not in IDLE.

## Operation
- **Synchronisers:** `usrt_clk`, `rxd` and `rts_in` each pass through a 2-flop synchroniser. A rising-edge pulse `bit_tick` is derived from synchronised `usrt_clk` compared with its previous value.
- **FSM states:** IDLE, DATA, PARITY (only with the macro), STOP. Every transition occurs only on `bit_tick`, except the RTS abort.
- **IDLE:** on `bit_tick` with `rts_in`=1 and `rxd`=0 (start bit), go to DATA and clear the bit counter. Ticks with `rxd`=1 are ignored.
- **DATA:** on each `bit_tick`, shift `rxd` into the shift register MSB with a right shift, so the first bit ends up as the LSB, and increment the counter. After `DATA_BITS` bits, go to PARITY, or to STOP if the macro is off.
- **PARITY:** on `bit_tick`, latch `rxd` as the received parity and go to STOP.
- **STOP, `rxd`=1:** load `rx_data`, pulse `rx_valid`, and pulse `par_err` if parity failed. `rx_data` is loaded even when parity fails. Go to IDLE.
- **STOP, `rxd`=0:** pulse `frame_err`, leave `rx_data` unchanged, go to IDLE.
- **RTS abort:** synchronised `rts_in`=0 in DATA, PARITY or STOP forces IDLE on the next `clk`, pulses `frame_err` and discards the partial word.
- **Back-to-back frames:** a start bit on the `bit_tick` immediately after the stop bit is accepted. There is no minimum idle time.
- **No backpressure:** the consumer must capture `rx_data` on `rx_valid`.
- **Reset:** `rst` mid-frame returns to IDLE and clears the counter and shift register. Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `par_err`=0, `busy`=0. Synchroniser flops reset to the idle levels: `usrt_clk`=0, `rxd`=1, `rts_in`=0.

## Timing
- `usrt_clk` high and low phases must each be at least 3 `clk` periods.
- Latency: if `usrt_clk` rises before `clk` edge k, `bit_tick` is high during cycle k+2, and the FSM and registered outputs update at edge k+2.
- `rx_valid`, `frame_err` and `par_err` are high for exactly one `clk`. They are never asserted together, except `rx_valid`+`par_err`.
- `busy` rises together with the start-bit acceptance. It falls in the same cycle as the `rx_valid` or `frame_err` strobe.

## Configuration
- **`USRT_RX_PARITY_EN` defined:** the frame is start, `DATA_BITS` data, even parity bit, stop. `par_err` is pulsed when the XOR of the data bits and the parity bit is 1.
- **Not defined:** the frame is start, data, stop. The PARITY state is absent and `par_err` is constant 0.

## Structure
- **Package `usrt_pkg`:** FSM state enum, `DATA_BITS` default, idle line level, and a `bit_cnt` width constant of clog2(`DATA_BITS`+1).
- **Sub-module `usrt_sync`:** 2-flop synchroniser with a parameterised reset value and an optional rising-edge output. It is instantiated three times, for `usrt_clk`, `rxd` and `rts_in`.

## Test plan
- RTS high, frame 0xA5 with good stop → `rx_data`=0xA5, a single `rx_valid` pulse, and `busy` low afterwards.
- Frame 0x3C with stop bit 0 → `frame_err` pulse, no `rx_valid`, `rx_data` keeps 0xA5.
- RTS dropped after 3 data bits, then 0x3C sent normally → one `frame_err` pulse, then `rx_data`=0x3C with `rx_valid`.
- Back-to-back 0x00 and 0xFF with no idle ticks → two `rx_valid` pulses with values 0x00 then 0xFF.
- `rst` asserted for 1 `clk` in the middle of the data bits → all outputs 0 and `busy`=0; the following frame 0x5A is received correctly.
- With `USRT_RX_PARITY_EN`: 0x81 with parity bit 0 → `rx_valid`, no `par_err`. 0x81 with parity bit 1 → `rx_valid`+`par_err`.

Source files
------------

// File: rtl/usrt_pkg.sv
// usrt_pkg: shared types and constants for the USRT receiver
package usrt_pkg;
  localparam int DATA_BITS_DEF = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam int BIT_CNT_W = $clog2(DATA_BITS_DEF + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/usrt_sync.sv
// usrt_sync: 2-flop synchroniser with reset value and optional rising-edge pulse
module usrt_sync #(
  parameter logic RST_VAL = 1'b0,
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic s1, s2, prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      prev <= s2;
    end
  end
  assign q = s2;
  assign rise = EDGE ? (s2 & ~prev) : 1'b0;
endmodule

// File: rtl/usrt_rx.sv
// usrt_rx: synchronous serial receiver sampling rxd on usrt_clk rising edges.
// Define USRT_RX_PARITY_EN to add an even parity bit before the stop bit.
import usrt_pkg::*;
module usrt_rx #(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 usrt_clk,
  input  logic                 rxd,
  input  logic                 rts_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS + 1);
  logic bit_tick, rxd_s, rts_s, unused_uclk_s, unused_rxd_rise, unused_rts_rise;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n, data_n;
  logic valid_n, ferr_n, perr_n;
  usrt_sync #(.RST_VAL(1'b0), .EDGE(1'b1)) u_clk_sync (
    .clk(clk), .rst(rst), .d(usrt_clk), .q(unused_uclk_s), .rise(bit_tick));
  usrt_sync #(.RST_VAL(LINE_IDLE)) u_rxd_sync (
    .clk(clk), .rst(rst), .d(rxd), .q(rxd_s), .rise(unused_rxd_rise));
  usrt_sync #(.RST_VAL(1'b0)) u_rts_sync (
    .clk(clk), .rst(rst), .d(rts_in), .q(rts_s), .rise(unused_rts_rise));
`ifdef USRT_RX_PARITY_EN
  logic par_bit, par_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shift_n = shift;
    data_n = rx_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    perr_n = 1'b0;
`ifdef USRT_RX_PARITY_EN
    par_n = par_bit;
`endif
    if (state != IDLE && !rts_s) begin
      // peer gave up mid-frame: drop the partial word
      state_n = IDLE;
      cnt_n = '0;
      shift_n = '0;
      ferr_n = 1'b1;
    end else if (bit_tick) begin
      case (state)
        IDLE: begin
          state_n = (rts_s && !rxd_s) ? DATA : IDLE;
          cnt_n = '0;
        end
        DATA: begin
          shift_n = {rxd_s, shift[DATA_BITS-1:1]};
          cnt_n = cnt + 1'b1;
`ifdef USRT_RX_PARITY_EN
          state_n = (cnt == CW'(DATA_BITS - 1)) ? PARITY : DATA;
`else
          state_n = (cnt == CW'(DATA_BITS - 1)) ? STOP : DATA;
`endif
        end
`ifdef USRT_RX_PARITY_EN
        PARITY: begin
          par_n = rxd_s;
          state_n = STOP;
        end
`endif
        STOP: begin
          state_n = IDLE;
          data_n = rxd_s ? shift : rx_data;
          valid_n = rxd_s;
          ferr_n = !rxd_s;
`ifdef USRT_RX_PARITY_EN
          perr_n = rxd_s && (^shift ^ par_bit);
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      rx_data <= data_n;
      rx_valid <= valid_n;
      frame_err <= ferr_n;
    end
  end
`ifdef USRT_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
      par_err <= 1'b0;
    end else begin
      par_bit <= par_n;
      par_err <= perr_n;
    end
  end
`else
  assign par_err = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_n;
`endif
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_usrt_rx.sv
// tb_usrt_rx: randomized self-checking bench for usrt_rx against a frame-level model
module tb_usrt_rx;
  logic clk = 1'b0, rst = 1'b1, usrt_clk = 1'b0, rxd = 1'b1, rts_in = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, par_err, busy;
  int n_run = 0, n_fail = 0;
  logic [7:0] vq[$];
  logic pq[$];
  int ferr_cnt = 0, excl_bad = 0;
  usrt_rx dut (
    .clk(clk), .rst(rst), .usrt_clk(usrt_clk), .rxd(rxd), .rts_in(rts_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .par_err(par_err), .busy(busy));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        vq.push_back(rx_data);
        pq.push_back(par_err);
      end
      if (frame_err) ferr_cnt++;
      if (frame_err && rx_valid) excl_bad++;
      if (par_err && !rx_valid) excl_bad++;
    end
  end
  task automatic clear_mon();
    vq.delete();
    pq.delete();
    ferr_cnt = 0;
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk);
    rxd = b;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    usrt_clk = 1'b1;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    usrt_clk = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic p);
    rts_in = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef USRT_RX_PARITY_EN
    send_bit(p);
`else
    if (p === 1'bx) $display("unexpected parity value");
`endif
    send_bit(stop);
  endtask
  function automatic logic even_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return logic'(ones % 2);
  endfunction
  task automatic idle_tick(input logic rts);
    rts_in = rts;
    send_bit(1'b1);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_run++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_run++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_run++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_run++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_good_frame();
    logic [7:0] d = 8'hA5;
    clear_mon();
    rts_in = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: got %b expected 1", busy); end
    for (int i = 4; i < 8; i++) send_bit(d[i]);
`ifdef USRT_RX_PARITY_EN
    send_bit(even_par(d));
`endif
    send_bit(1'b1);
    repeat (2) @(negedge clk);
    n_run++; if (vq.size() != 1) begin n_fail++; $display("FAIL good_valid_count: got %0d expected 1", vq.size()); end
    n_run++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL good_rx_data: got %h expected a5", rx_data); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_after: got %b expected 0", busy); end
    n_run++; if (ferr_cnt != 0) begin n_fail++; $display("FAIL good_frame_err: got %0d expected 0", ferr_cnt); end
  endtask
  task automatic test_bad_stop();
    clear_mon();
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    idle_tick(1'b1);
    n_run++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL badstop_ferr: got %0d expected 1", ferr_cnt); end
    n_run++; if (vq.size() != 0) begin n_fail++; $display("FAIL badstop_valid: got %0d expected 0", vq.size()); end
    n_run++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL badstop_rx_data: got %h expected a5", rx_data); end
  endtask
  task automatic test_rts_abort();
    clear_mon();
    rts_in = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    idle_tick(1'b0);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    send_frame(8'h3C, 1'b1, even_par(8'h3C));
    repeat (2) @(negedge clk);
    n_run++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL abort_ferr: got %0d expected 1", ferr_cnt); end
    n_run++; if (vq.size() != 1 || rx_data !== 8'h3C) begin n_fail++; $display("FAIL abort_next_frame: got %0d valids data %h expected 1 valid data 3c", vq.size(), rx_data); end
  endtask
  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    n_run++; if (vq.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", vq.size()); end
    else begin
      n_run++; if (vq[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h expected 00", vq[0]); end
      n_run++; if (vq[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h expected ff", vq[1]); end
    end
  endtask
  task automatic test_mid_reset();
    clear_mon();
    rts_in = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_run++; if ({rx_data, rx_valid, frame_err, par_err, busy} !== 12'h000) begin n_fail++; $display("FAIL midrst_outputs: got data %h v%b f%b p%b busy %b expected all 0", rx_data, rx_valid, frame_err, par_err, busy); end
    idle_tick(1'b0);
    clear_mon();
    send_frame(8'h5A, 1'b1, even_par(8'h5A));
    repeat (2) @(negedge clk);
    n_run++; if (vq.size() != 1 || rx_data !== 8'h5A) begin n_fail++; $display("FAIL midrst_next_frame: got %0d valids data %h expected 1 valid data 5a", vq.size(), rx_data); end
  endtask
`ifdef USRT_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    n_run++; if (vq.size() != 2) begin n_fail++; $display("FAIL par_count: got %0d expected 2", vq.size()); end
    else begin
      n_run++; if (pq[0] !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b expected 0", pq[0]); end
      n_run++; if (pq[1] !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b expected 1", pq[1]); end
      n_run++; if (vq[1] !== 8'h81) begin n_fail++; $display("FAIL par_bad_data: got %h expected 81", vq[1]); end
    end
  endtask
`endif
  task automatic test_random();
    logic [7:0] exp_d[$];
    logic exp_p[$];
    logic [7:0] last = rx_data;
    int exp_ferr = 0;
    clear_mon();
    for (int f = 0; f < 16; f++) begin
      logic [7:0] d = 8'($urandom);
      logic stop = ($urandom_range(0, 3) != 0);
      logic p = 1'($urandom);
      send_frame(d, stop, p);
      if (stop) begin
        last = d;
        exp_d.push_back(d);
`ifdef USRT_RX_PARITY_EN
        exp_p.push_back(p ^ even_par(d));
`else
        exp_p.push_back(1'b0);
`endif
      end else exp_ferr++;
      if ($urandom_range(0, 2) == 0) idle_tick(1'b1);
      repeat (2) @(negedge clk);
      n_run++; if (rx_data !== last) begin n_fail++; $display("FAIL rand_rx_data[%0d]: got %h expected %h", f, rx_data, last); end
    end
    n_run++; if (ferr_cnt != exp_ferr) begin n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt, exp_ferr); end
    n_run++; if (vq.size() != exp_d.size()) begin n_fail++; $display("FAIL rand_valid_count: got %0d expected %0d", vq.size(), exp_d.size()); end
    else for (int i = 0; i < exp_d.size(); i++) begin
      n_run++; if (vq[i] !== exp_d[i] || pq[i] !== exp_p[i]) begin n_fail++; $display("FAIL rand_word[%0d]: got %h/p%b expected %h/p%b", i, vq[i], pq[i], exp_d[i], exp_p[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_bad_stop();
    test_rts_abort();
    test_back_to_back();
    test_mid_reset();
`ifdef USRT_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    n_run++; if (excl_bad != 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", excl_bad); end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
